uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter g_System_Clk, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter g_Baud_Rate, default 9600, serial bit rate in baud.
REQ-003 SHALL have port i_Clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_Rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_RX, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port o_RX_DV, output, 1 bit: one-cycle pulse when a received byte is valid.
REQ-007 SHALL have port o_RX_Byte, output, 8 bits: last received byte, held until the next byte completes.

Function
REQ-008 SHALL define CLKS_PER_BIT = g_System_Clk / g_Baud_Rate, using integer truncation (10416 at defaults).
- Counter width SHALL be $clog2(CLKS_PER_BIT).
REQ-009 SHALL pass i_RX through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-010 SHALL use frame format 8N1: start bit 0, 8 data bits LSB first, stop bit 1.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, CLEANUP.
REQ-012 In IDLE, a synchronized low level SHALL enter START with count 0.
- Detection is level-based, not edge-based, so a line already low out of reset starts a frame.
REQ-013 START SHALL count to (CLKS_PER_BIT-1)/2 (mid start bit), then re-sample.
- Still low -> DATA with count 0 and bit index 0.
- High -> IDLE (glitch rejection).
REQ-014 DATA SHALL wait CLKS_PER_BIT cycles per bit and sample at each mid-bit.
- Sample is stored at bit index position; index increments 0..7.
- After bit 7 -> STOP.
REQ-015 STOP SHALL wait CLKS_PER_BIT cycles, sample the stop bit, load o_RX_Byte from the shift register, pulse o_RX_DV for exactly 1 cycle, then -> CLEANUP.
REQ-016 CLEANUP SHALL last 1 cycle, drive o_RX_DV low, then -> IDLE.
- A following start bit is therefore accepted after half a stop bit.
REQ-017 Latency: o_RX_DV SHALL assert at 2 + 9.5*CLKS_PER_BIT cycles (±2) after the start-bit falling edge.
- This is before the end of the stop bit.
REQ-018 o_RX_Byte SHALL change only in the cycle o_RX_DV asserts; it SHALL NOT change on an aborted (glitch) start.

Reset
REQ-019 i_Rst high at a clock edge SHALL force state IDLE, counters 0, bit index 0, shift register 0x00, o_RX_Byte = 0x00, o_RX_DV = 0, synchronizer flops = 1.
REQ-020 Reset mid-frame SHALL abort the frame with no o_RX_DV pulse; reception resumes from IDLE on the next low level.

Configuration
REQ-021 Macro UART_RX_FRAME_ERR_EN SHALL control framing-error detection.
- Defined: adds output o_Frame_Err (1 bit, reset 0).
- Stop sample 0: o_Frame_Err pulses 1 cycle in place of o_RX_DV, and o_RX_Byte is not updated.
- Stop sample 1: behaviour per REQ-015.
- Undefined: no o_Frame_Err port; the stop-bit value is ignored and REQ-015 applies regardless.

Structure
REQ-022 Package uart_pkg SHALL hold the state enum (IDLE..CLEANUP) and a constant function computing CLKS_PER_BIT.
REQ-023 Sub-module uart_rx_sync SHALL implement the 2-flop synchronizer with reset value 1.
- It is the only sub-module.

Verification
REQ-024 Defaults; i_RX low from time 0, then send 0xAA (LSB first) at 104167 ns/bit, then stop bit 1 -> o_RX_Byte = 0xAA and one o_RX_DV pulse, both before 10 bit periods elapse.
REQ-025 Two back-to-back frames 0x55 then 0xFF -> two o_RX_DV pulses, carrying 0x55 then 0xFF.
REQ-026 Low glitch of 0.3 bit period on an idle line -> no o_RX_DV, o_RX_Byte unchanged, state returns to IDLE.
REQ-027 Assert i_Rst at data bit 4 of frame 0x3C -> no o_RX_DV; next frame 0xC3 received correctly.
REQ-028 With UART_RX_FRAME_ERR_EN, send 0x81 with stop bit 0 -> o_Frame_Err 1-cycle pulse, no o_RX_DV, o_RX_Byte holds the previous value.
REQ-029 Parameters 50_000_000 / 115200 (CLKS_PER_BIT = 434), send 0x00 -> o_RX_Byte = 0x00 with o_RX_DV at about 9.5 bit periods.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver slice.
//   rx_state_e   - receiver state encoding (IDLE..CLEANUP)
//   clks_per_bit - system clocks per serial bit, integer-truncated
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } rx_state_e;

    localparam int unsigned DATA_BITS = 8;

    // Truncating division so non-integer ratios round down.
    function automatic int unsigned clks_per_bit(input int unsigned sys_clk,
                                                 input int unsigned baud);
        return sys_clk / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: groups the serial line and the received-byte outputs of uart_rx.
//   rx        - serial line, idle high (driven by the line source)
//   rx_dv     - one-cycle byte-valid pulse
//   rx_byte   - last received byte
//   frame_err - one-cycle framing-error pulse (only with UART_RX_FRAME_ERR_EN)
// master = serial source / byte consumer, slave = receiver.
interface uart_rx_if;
    logic       rx;
    logic       rx_dv;
    logic [7:0] rx_byte;
`ifdef UART_RX_FRAME_ERR_EN
    logic       frame_err;
`endif

    modport master (
        output rx,
        input  rx_dv,
        input  rx_byte
`ifdef UART_RX_FRAME_ERR_EN
        , input frame_err
`endif
    );

    modport slave (
        input  rx,
        output rx_dv,
        output rx_byte
`ifdef UART_RX_FRAME_ERR_EN
        , output frame_err
`endif
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the asynchronous serial line.
//   clk     - system clock
//   rst     - synchronous active-high reset (flops reset to 1 = idle line)
//   async_i - asynchronous input
//   sync_o  - synchronized output
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling.
//   i_Clk       - system clock, rising edge
//   i_Rst       - synchronous active-high reset
//   i_RX        - asynchronous serial line, idle high
//   o_RX_DV     - one-cycle pulse when o_RX_Byte holds a new byte
//   o_RX_Byte   - last received byte, held until the next one completes
//   o_Frame_Err - one-cycle pulse on a low stop bit (UART_RX_FRAME_ERR_EN only)
// Optional feature macro: UART_RX_FRAME_ERR_EN (framing-error detection).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned g_System_Clk = 100_000_000,
    parameter int unsigned g_Baud_Rate  = 9600
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_RX,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
`ifdef UART_RX_FRAME_ERR_EN
    , output logic     o_Frame_Err
`endif
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(g_System_Clk, g_Baud_Rate);
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned HALF_BIT     = (CLKS_PER_BIT - 1) / 2;
    localparam int unsigned IDX_W        = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    rx_state_e            state_q,    state_d;
    logic [CNT_W-1:0]     cnt_q,      cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,  bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] rx_byte_q,  rx_byte_d;
    logic                 rx_dv_q,    rx_dv_d;
    logic                 rx_sync;
`ifdef UART_RX_FRAME_ERR_EN
    logic                 frame_err_q, frame_err_d;
`endif

    uart_rx_sync u_sync (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .async_i (i_RX),
        .sync_o  (rx_sync)
    );

    // State and datapath registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err_q <= frame_err_d;
`endif
        end
    end

    // Next-state and output logic; pulses default low so they last one cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_byte_d   = rx_byte_q;
        rx_dv_d     = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
        frame_err_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                // Level-triggered: a line already low starts a frame
                if (!rx_sync) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    // High again at mid start bit means it was a glitch
                    state_d   = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rx_sync;
                    if (bit_idx_q == IDX_LAST) begin
                        bit_idx_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = CLEANUP;
`ifdef UART_RX_FRAME_ERR_EN
                    if (rx_sync) begin
                        rx_byte_d = shift_q;
                        rx_dv_d   = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
`else
                    rx_byte_d = shift_q;
                    rx_dv_d   = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            CLEANUP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
`ifdef UART_RX_FRAME_ERR_EN
    assign o_Frame_Err = frame_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed + randomized bench for uart_rx.
// DUT A uses a scaled clock/baud pair (16 clocks per bit after truncation),
// DUT B uses 50 MHz / 115200 (434 clocks per bit).
module tb_uart_rx;

    localparam int unsigned SYS_A  = 1_000_000;
    localparam int unsigned BAUD_A = 60_000;
    localparam int unsigned SYS_B  = 50_000_000;
    localparam int unsigned BAUD_B = 115_200;
    localparam int CPB_A = int'(SYS_A / BAUD_A);
    localparam int CPB_B = int'(SYS_B / BAUD_B);

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_if u_if_a ();
    uart_rx_if u_if_b ();

    uart_rx #(.g_System_Clk(SYS_A), .g_Baud_Rate(BAUD_A)) u_dut_a (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_RX        (u_if_a.rx),
        .o_RX_DV     (u_if_a.rx_dv),
        .o_RX_Byte   (u_if_a.rx_byte)
`ifdef UART_RX_FRAME_ERR_EN
        , .o_Frame_Err (u_if_a.frame_err)
`endif
    );

    uart_rx #(.g_System_Clk(SYS_B), .g_Baud_Rate(BAUD_B)) u_dut_b (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_RX        (u_if_b.rx),
        .o_RX_DV     (u_if_b.rx_dv),
        .o_RX_Byte   (u_if_b.rx_byte)
`ifdef UART_RX_FRAME_ERR_EN
        , .o_Frame_Err (u_if_b.frame_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: pulse counts, pulse timestamps, width and hold checks
    int         dv_cnt_a = 0, dv_cnt_b = 0;
    int         dv_cyc_a = 0, dv_cyc_b = 0;
    logic [7:0] dv_byte_a = '0, dv_byte_b = '0;
    int         dbl_a = 0, dbl_b = 0;
    int         bad_chg_a = 0, bad_chg_b = 0;
    int         ferr_cnt_a = 0, ferr_cnt_b = 0;
    logic       dv_prev_a = 1'b0, dv_prev_b = 1'b0;
    logic [7:0] byte_prev_a = '0, byte_prev_b = '0;

    always @(negedge clk) begin
        if (rst) begin
            dv_prev_a   = 1'b0;
            byte_prev_a = u_if_a.rx_byte;
        end else begin
            if (u_if_a.rx_dv) begin
                dv_cnt_a++;
                dv_cyc_a  = cyc;
                dv_byte_a = u_if_a.rx_byte;
                if (dv_prev_a) dbl_a++;
            end else if (u_if_a.rx_byte !== byte_prev_a) begin
                bad_chg_a++;
            end
`ifdef UART_RX_FRAME_ERR_EN
            if (u_if_a.frame_err) ferr_cnt_a++;
`endif
            dv_prev_a   = u_if_a.rx_dv;
            byte_prev_a = u_if_a.rx_byte;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            dv_prev_b   = 1'b0;
            byte_prev_b = u_if_b.rx_byte;
        end else begin
            if (u_if_b.rx_dv) begin
                dv_cnt_b++;
                dv_cyc_b  = cyc;
                dv_byte_b = u_if_b.rx_byte;
                if (dv_prev_b) dbl_b++;
            end else if (u_if_b.rx_byte !== byte_prev_b) begin
                bad_chg_b++;
            end
`ifdef UART_RX_FRAME_ERR_EN
            if (u_if_b.frame_err) ferr_cnt_b++;
`endif
            dv_prev_b   = u_if_b.rx_dv;
            byte_prev_b = u_if_b.rx_byte;
        end
    end

    // Reference state: the byte each receiver should currently be presenting
    logic [7:0] model_byte [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) u_if_a.rx = v;
        else            u_if_b.rx = v;
    endtask

    // Serialise one 8N1 frame and check it against the reference rules
    task automatic run_frame(input int which, input logic [7:0] b, input logic stop_v,
                             input string tag);
        int   cpb, dv0, fe0, t0, lat, dv_now, fe_now, nominal2;
        logic exp_dv;
        logic [7:0] got_byte;
        cpb = (which == 0) ? CPB_A : CPB_B;
        dv0 = (which == 0) ? dv_cnt_a : dv_cnt_b;
        fe0 = (which == 0) ? ferr_cnt_a : ferr_cnt_b;
        t0  = cyc;
        drive(which, 1'b0);
        wait_cyc(cpb);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            wait_cyc(cpb);
        end
        drive(which, stop_v);
        wait_cyc(cpb);
        drive(which, 1'b1);
        wait_cyc(2);

`ifdef UART_RX_FRAME_ERR_EN
        exp_dv = stop_v;
`else
        exp_dv = 1'b1;
`endif
        if (exp_dv) model_byte[which] = b;

        dv_now   = (which == 0) ? dv_cnt_a : dv_cnt_b;
        fe_now   = (which == 0) ? ferr_cnt_a : ferr_cnt_b;
        got_byte = (which == 0) ? u_if_a.rx_byte : u_if_b.rx_byte;
        check({tag, "/dv_pulses"}, dv_now - dv0, exp_dv ? 1 : 0);
        check({tag, "/byte"}, int'(got_byte), int'(model_byte[which]));
`ifdef UART_RX_FRAME_ERR_EN
        check({tag, "/frame_err_pulses"}, fe_now - fe0, exp_dv ? 0 : 1);
`else
        check({tag, "/no_frame_err"}, fe_now - fe0, 0);
`endif
        if (exp_dv) begin
            lat      = ((which == 0) ? dv_cyc_a : dv_cyc_b) - t0;
            nominal2 = 4 + 19 * cpb;  // twice (2 + 9.5*CLKS_PER_BIT)
            check({tag, "/byte_at_dv"}, int'((which == 0) ? dv_byte_a : dv_byte_b), int'(b));
            check({tag, "/latency_in_window"},
                  int'((2 * lat >= nominal2 - 4) && (2 * lat <= nominal2 + 4)), 1);
            check({tag, "/dv_before_10_bits"}, int'(lat < 10 * cpb), 1);
        end
    endtask

    initial begin
        logic [7:0] rb;
        int         gap;
        int         dv0;

        model_byte[0] = '0;
        model_byte[1] = '0;
        u_if_a.rx = 1'b0;  // line A low from time 0
        u_if_b.rx = 1'b1;
        rst = 1'b1;
        wait_cyc(3);

        check("reset/dv_a",   int'(u_if_a.rx_dv),   0);
        check("reset/byte_a", int'(u_if_a.rx_byte), 0);
        check("reset/dv_b",   int'(u_if_b.rx_dv),   0);
        check("reset/byte_b", int'(u_if_b.rx_byte), 0);

        // Line already low when reset releases: that low is the start bit
        rst = 1'b0;
        run_frame(0, 8'hAA, 1'b1, "aa_from_reset");

        // Back-to-back frames
        run_frame(0, 8'h55, 1'b1, "b2b_55");
        run_frame(0, 8'hFF, 1'b1, "b2b_ff");

        // Short low glitch on an idle line
        wait_cyc(CPB_A);
        dv0 = dv_cnt_a;
        drive(0, 1'b0);
        wait_cyc((CPB_A * 3) / 10);
        drive(0, 1'b1);
        wait_cyc(2 * CPB_A);
        check("glitch/dv_pulses", dv_cnt_a - dv0, 0);
        check("glitch/byte", int'(u_if_a.rx_byte), int'(model_byte[0]));
        run_frame(0, 8'h96, 1'b1, "after_glitch");

        // Randomized frames with random idle gaps
        for (int k = 0; k < 6; k++) begin
            rb  = 8'($urandom);
            gap = int'($urandom_range(0, CPB_A));
            if (gap > 0) wait_cyc(gap);
            run_frame(0, rb, 1'b1, "random");
        end

        // Reset during data bit 4 of 0x3C
        wait_cyc(CPB_A);
        dv0 = dv_cnt_a;
        rb  = 8'h3C;
        drive(0, 1'b0);
        wait_cyc(CPB_A);
        for (int i = 0; i < 4; i++) begin
            drive(0, rb[i]);
            wait_cyc(CPB_A);
        end
        drive(0, rb[4]);
        wait_cyc(CPB_A / 2);
        rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        model_byte[0] = '0;
        model_byte[1] = '0;
        drive(0, 1'b1);
        wait_cyc(12 * CPB_A);
        check("reset_mid/dv_pulses", dv_cnt_a - dv0, 0);
        check("reset_mid/byte", int'(u_if_a.rx_byte), int'(model_byte[0]));
        run_frame(0, 8'hC3, 1'b1, "after_reset_c3");

        // Low stop bit; the tail of the low stop bit must not start a frame
        run_frame(0, 8'h81, 1'b0, "stop_low_81");
        dv0 = dv_cnt_a;
        wait_cyc(12 * CPB_A);
        check("stop_low/no_false_frame", dv_cnt_a - dv0, 0);
        run_frame(0, 8'h4E, 1'b1, "after_stop_low");

        // Faster-clock configuration at 434 clocks per bit
        run_frame(1, 8'h00, 1'b1, "b_00");
        rb = 8'($urandom);
        run_frame(1, rb, 1'b1, "b_random");

        check("a/double_pulse", dbl_a, 0);
        check("a/byte_changed_without_dv", bad_chg_a, 0);
        check("b/double_pulse", dbl_b, 0);
        check("b/byte_changed_without_dv", bad_chg_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
